// File: rtl/led_sequencer.sv
// Four-LED pattern engine: OFF/STATIC/BLINK/CHASE driven by a prescaled tick, with PWM dimming.
// Optional build macro LED_ACTIVE_LOW_EN inverts the leds output for active-low boards.
module led_sequencer #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned STEP_TICKS = 250,
  parameter int unsigned PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [3:0]          cmd_pattern,
  input  logic [PWM_BITS-1:0] cmd_bright,
  output logic [3:0]          leds,
  output logic                step,
  output logic [1:0]          mode_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] LedsRst = 4'b1111;
`else
  localparam logic [3:0] LedsRst = 4'b0000;
`endif

  typedef enum logic [2:0] {StOff, StLoad, StStatic, StBlink, StChase} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       stp_cnt_q, stp_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                phase_q, phase_d;
  logic [3:0]          chase_q, chase_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          pattern_q, pattern_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [3:0]          leds_q, leds_d;
  logic                step_q, step_d;
  logic [1:0]          mode_o_q, mode_o_d;

  logic       accept, tick, wrap, pwm_on;
  logic [3:0] raw, lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StOff;
      presc_q   <= '0;
      stp_cnt_q <= '0;
      pwm_cnt_q <= '0;
      phase_q   <= 1'b0;
      chase_q   <= 4'b0000;
      mode_q    <= 2'd0;
      pattern_q <= 4'b0000;
      bright_q  <= '0;
      leds_q    <= LedsRst;
      step_q    <= 1'b0;
      mode_o_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      stp_cnt_q <= stp_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      phase_q   <= phase_d;
      chase_q   <= chase_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      bright_q  <= bright_d;
      leds_q    <= leds_d;
      step_q    <= step_d;
      mode_o_q  <= mode_o_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    stp_cnt_d = stp_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    phase_d   = phase_q;
    chase_d   = chase_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    bright_d  = bright_q;
    leds_d    = leds_q;
    step_d    = 1'b0;
    mode_o_d  = mode_o_q;
    raw       = 4'b0000;

    cmd_ready = (state_q != StLoad);
    accept    = cmd_valid && cmd_ready;
    tick      = (presc_q == PW'(TICK_DIV - 1));
    wrap      = tick && (stp_cnt_q == SW'(STEP_TICKS - 1));
    pwm_on    = (&bright_q) || (pwm_cnt_q < bright_q);

    unique case (state_q)
      StStatic: raw = pattern_q;
      StBlink:  raw = phase_q ? pattern_q : 4'b0000;
      StChase:  raw = chase_q;
      default:  raw = 4'b0000;
    endcase
    lit = raw & {4{pwm_on}};

    if (state_q == StLoad) begin
      presc_d   = '0;
      stp_cnt_d = '0;
      pwm_cnt_d = '0;
      phase_d   = 1'b1;
      chase_d   = pattern_q;
      mode_o_d  = mode_q;
      unique case (mode_q)
        2'd1:    state_d = StStatic;
        2'd2:    state_d = StBlink;
        2'd3:    state_d = StChase;
        default: state_d = StOff;
      endcase
    end else begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      if (tick) begin
        stp_cnt_d = wrap ? '0 : stp_cnt_q + SW'(1);
      end
      step_d = wrap && ((state_q == StBlink) || (state_q == StChase));
      if (wrap && (state_q == StBlink)) phase_d = ~phase_q;
      if (wrap && (state_q == StChase)) chase_d = {chase_q[2:0], chase_q[3]};
`ifdef LED_ACTIVE_LOW_EN
      leds_d = ~lit;
`else
      leds_d = lit;
`endif
    end

    // An accepted command overrides any step effect; LOAD reinitialises everything.
    if (accept) begin
      state_d   = StLoad;
      mode_d    = cmd_mode;
      pattern_d = cmd_pattern;
      bright_d  = cmd_bright;
    end
  end

  assign leds   = leds_q;
  assign step   = step_q;
  assign mode_o = mode_o_q;

endmodule
